vga_port_regbank: RTL

VGA_PORT_REGBANK -- requirements
Module: vga_port_regbank

---
 rtl/vga_port_regbank_if.sv | 19 +
 rtl/vga_port_regbank.sv | 115 +++++++++++
 2 files changed

// File: rtl/vga_port_regbank_if.sv
// Microcontroller port bus shared by the register bank and its host.
// The master drives address, data and strobes; the slave returns read data.
interface vga_port_regbank_if;
  logic [7:0] Port_ID;
  logic [7:0] IN_DATA;
  logic       Read_Strobe;
  logic       Write_Strobe;
  logic [7:0] OUT_DATA;

  modport master (
    output Port_ID, IN_DATA, Read_Strobe, Write_Strobe,
    input  OUT_DATA
  );

  modport slave (
    input  Port_ID, IN_DATA, Read_Strobe, Write_Strobe,
    output OUT_DATA
  );
endinterface

// File: rtl/vga_port_regbank.sv
// Double-buffered 16x8 register bank: the microcontroller fills a shadow bank,
// which is copied to the renderer's display bank on a VSync falling edge.
module vga_port_regbank #(
  parameter logic [7:0] ADDR_PORT   = 8'd40,
  parameter logic [7:0] DATA_PORT   = 8'd41,
  parameter logic [7:0] STATUS_PORT = 8'd2
) (
  input  logic                CLK,
  input  logic                RESET,
  vga_port_regbank_if.slave   bus,
  input  logic                VSync,
  input  logic [3:0]          RD_ADDR,
  output logic [7:0]          RD_DATA
);

  typedef enum logic {IDLE, COPY} state_t;

  state_t     state, state_nx;
  logic       ws_p1, vs_p1;
  logic [3:0] ptr, idx;
  logic       dirty;
  logic [7:0] shadow  [16];
  logic [7:0] display [16];
  logic       wr_edge, vs_fall, addr_wr, data_wr, copy_start;
  logic [7:0] out_mux;
  logic       read_unused;

  // Reads are side-effect free, so the read qualifier is not needed.
  assign read_unused = bus.Read_Strobe;

  assign wr_edge = bus.Write_Strobe & ~ws_p1;
  assign vs_fall = vs_p1 & ~VSync;
  assign addr_wr = wr_edge && (bus.Port_ID == ADDR_PORT);
  assign data_wr = wr_edge && (bus.Port_ID == DATA_PORT);

  always_comb begin
    state_nx   = state;
    copy_start = 1'b0;
    case (state)
      IDLE: begin
        if (vs_fall && dirty) begin
          state_nx   = COPY;
          copy_start = 1'b1;
        end
      end
      COPY: begin
        if (idx == 4'd15) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_mux = 8'h00;
    if (bus.Port_ID == STATUS_PORT)
      out_mux = {5'b0, (state == COPY), dirty, ~vs_p1};
    else if (bus.Port_ID == ADDR_PORT)
      out_mux = {4'b0, ptr};
    else if (bus.Port_ID == DATA_PORT)
      out_mux = shadow[ptr];
  end

  // p1: edge-detect registers, pointer, dirty flag and copy FSM
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ws_p1 <= 1'b0;
      vs_p1 <= 1'b1;
      ptr   <= 4'd0;
      idx   <= 4'd0;
      dirty <= 1'b0;
    end else begin
      state <= state_nx;
      ws_p1 <= bus.Write_Strobe;
      vs_p1 <= VSync;
      if (addr_wr)
        ptr <= bus.IN_DATA[3:0];
      else if (data_wr)
        ptr <= ptr + 4'd1;
      // A write landing on the copy-start cycle keeps dirty set for the next frame.
      if (data_wr)
        dirty <= 1'b1;
      else if (copy_start)
        dirty <= 1'b0;
      if (copy_start)
        idx <= 4'd0;
      else if (state == COPY)
        idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow  <= '{default: 8'h00};
      display <= '{default: 8'h00};
    end else begin
      if (data_wr)
        shadow[ptr] <= bus.IN_DATA;
      if (state == COPY)
        display[idx] <= shadow[idx];
    end
  end

  // p1: registered read ports; the display read sees the pre-copy value
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.OUT_DATA <= 8'h00;
      RD_DATA      <= 8'h00;
    end else begin
      bus.OUT_DATA <= out_mux;
      RD_DATA      <= display[RD_ADDR];
    end
  end

endmodule
